// File: rtl/hazard_controller.sv
// Hazard controller for the five-stage integer pipeline.
// A two-entry shadow of the EX and MEM stages is compared against the
// sources of the instruction sitting in ID. From that comparison the block
// decides whether ID has to be held for a cycle (load-use, or a branch whose
// operand is not ready yet) and which forwarding path each operand should use.
// A saturating counter records how many cycles were lost to stalls.

module hazard_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rS1,
   input  logic [4:0]  rS2,
   input  logic        useS1,
   input  logic        useS2,
   input  logic [4:0]  rWId,
   input  logic        regWrId,
   input  logic        loadId,
   input  logic        branchId,
   output logic        stall,
   output logic        ifIdWrIn,
   output logic        bubble,
   output logic        exMemIdA,
   output logic        exMemIdB,
   output logic        exMemExA,
   output logic        exMemExB,
   output logic        memWbExA,
   output logic        memWbExB,
   output logic [15:0] stallCycles
);

   // One shadow entry describes an instruction further down the pipe:
   // whether a real instruction occupies the slot, which register it
   // writes, whether it writes at all, and whether its value comes from
   // data memory (and so is not ready until the end of MEM).
   typedef struct packed {
      logic       valid;
      logic [4:0] rW;
      logic       regWr;
      logic       load;
   } shadowEntry_t;

   localparam logic [15:0] StallCountMax = 16'hFFFF;

   shadowEntry_t exShadow;
   shadowEntry_t memShadow;
   shadowEntry_t exNext;

   logic s1MatchEx;
   logic s1MatchMem;
   logic s2MatchEx;
   logic s2MatchMem;

   logic loadUseStall;
   logic branchStall;

   logic s1FwdEx;
   logic s2FwdEx;

   logic [15:0] stallCount;

   // A source only depends on a producer if ID really reads it, it is not
   // r0 (hard-wired zero), and the producer is a live instruction that
   // writes that very register.
   function automatic logic srcMatches(
      input logic         useSrc,
      input logic [4:0]   src,
      input shadowEntry_t entry
   );
      return useSrc && (src != 5'd0) && entry.valid && entry.regWr &&
             (entry.rW == src);
   endfunction

   // Compare both ID sources against both shadow entries. The register file
   // itself writes on the falling clock, so a producer that has already left
   // MEM is visible through the normal read path and needs no entry here.
   always_comb begin
      s1MatchEx  = srcMatches(useS1, rS1, exShadow);
      s1MatchMem = srcMatches(useS1, rS1, memShadow);
      s2MatchEx  = srcMatches(useS2, rS2, exShadow);
      s2MatchMem = srcMatches(useS2, rS2, memShadow);
   end

   // Decide whether ID must wait. A load in EX cannot feed anything yet, so
   // any reader stalls once. A branch resolves in ID and needs busA right
   // now: an ALU result still in EX is one cycle too late, and a load is
   // usable by the branch only once it has left MEM, hence two cycles.
   always_comb begin
      loadUseStall = (s1MatchEx || s2MatchEx) && exShadow.load;
      branchStall  = branchId && (s1MatchEx || (s1MatchMem && memShadow.load));
      stall        = loadUseStall || branchStall;
   end

   assign ifIdWrIn = ~stall;
   assign bubble   = stall;

   // The EX-stage forward from the EX/MEM register only makes sense for a
   // non-load; a load in EX always stalls instead.
   always_comb begin
      s1FwdEx = s1MatchEx && !exShadow.load;
      s2FwdEx = s2MatchEx && !exShadow.load;
   end

   // Pick forwarding paths for the operands. The newest producer wins, so
   // the MEM/WB path is only used when EX/MEM does not already supply the
   // value. The ID-stage forward taps aluResultMem, which holds nothing
   // useful for a load. A stalled instruction turns into a bubble, so none
   // of its forward selects may leak into ID/EX.
   always_comb begin
      exMemIdA = 1'b0;
      exMemIdB = 1'b0;
      exMemExA = 1'b0;
      exMemExB = 1'b0;
      memWbExA = 1'b0;
      memWbExB = 1'b0;
      if (!stall) begin
         exMemIdA = s1MatchMem && !memShadow.load;
         exMemIdB = s2MatchMem && !memShadow.load;
         exMemExA = s1FwdEx;
         exMemExB = s2FwdEx;
         memWbExA = s1MatchMem && !s1FwdEx;
         memWbExB = s2MatchMem && !s2FwdEx;
      end
   end

   // Describe what enters EX on the next edge: the ID instruction, or an
   // empty slot when it is being held back.
   always_comb begin
      exNext = '0;
      if (!stall) begin
         exNext.valid = 1'b1;
         exNext.rW    = rWId;
         exNext.regWr = regWrId;
         exNext.load  = loadId;
      end
   end

   // Advance the shadow pipeline one stage per clock. Reset clears both
   // entries at once, which removes every match and therefore drops any
   // stall without waiting for the clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exShadow  <= '0;
         memShadow <= '0;
      end else begin
         memShadow <= exShadow;
         exShadow  <= exNext;
      end
   end

   // Count stalled cycles for performance monitoring. The counter sticks at
   // its maximum rather than wrapping, so a long run never reads as few
   // stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stallCount <= 16'd0;
      end else if (stall && (stallCount != StallCountMax)) begin
         stallCount <= stallCount + 16'd1;
      end
   end

   assign stallCycles = stallCount;

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-high reset; clears all state immediately, independent of clk.
REQ-003 rS1, rS2  input  5 each  source register numbers of the instruction in ID.
REQ-004 useS1, useS2  input  1 each  ID instruction actually reads rS1 / rS2.
REQ-005 rWId  input  5  destination register of the ID instruction (after regDst/link muxing).
REQ-006 regWrId  input  1  ID instruction writes the integer register file.
REQ-007 loadId  input  1  ID instruction is a load (result comes from data memory).
REQ-008 branchId  input  1  ID instruction is a branch/jump-register that consumes busA in ID.
REQ-009 stall  output  1  hold IF/ID and insert a bubble this cycle.
REQ-010 ifIdWrIn  output  1  IF/ID write enable; equals ~stall.
REQ-011 bubble  output  1  zero aluCtrl/exCtrl/memCtrl/wrCtrl entering ID/EX; equals stall.
REQ-012 exMemIdA, exMemIdB  output  1 each  ID-stage forward from aluResultMem (idCtrl[1], idCtrl[2]).
REQ-013 exMemExA, exMemExB, memWbExA, memWbExB  output  1 each  EX-forward selects issued in ID (exCtrl[3..6]).
REQ-014 stallCycles  output  16  saturating count of stalled cycles.

Function
REQ-015 The block SHALL keep a shadow pipeline with two entries, EXs and MEMs; each entry holds {valid, rW[4:0], regWr, load}.
REQ-016 On each rising clk edge: MEMs <= EXs, and EXs <= {1, rWId, regWrId, loadId}, or all-zero when stall=1.
REQ-017 Register-file writeback needs no forward to ID, because the file writes on ~clk; there is no WB shadow entry.
REQ-018 A match on source X (S1 or S2) against entry E SHALL require all of: useX, rSX != 0, E.valid, E.regWr, E.rW == rSX.
REQ-019 Load-use stall: match of S1 or S2 against EXs with EXs.load=1.
REQ-020 Branch stall, any one of:
  - branchId and S1 matches EXs (any kind);
  - branchId and S1 matches MEMs with MEMs.load=1.
REQ-021 stall SHALL be the combinational OR of REQ-019 and REQ-020.
REQ-022 exMemIdA SHALL be 1 when S1 matches MEMs and MEMs.load=0; exMemIdB is the same for S2.
REQ-023 exMemExX SHALL be 1 when X matches EXs and EXs.load=0.
REQ-024 memWbExX SHALL be 1 when X matches MEMs and exMemExX=0; newest producer wins.
REQ-025 While stall=1, all exMem*/memWb* outputs SHALL be 0, since the bubbled instruction carries no forwarding.
REQ-026 A load dependency resolves after exactly 1 stall cycle: the load moves to MEMs and memWbEx then selects busW.
REQ-027 Branch dependency latency:
  - on an ALU producer, 1 stall cycle, then forwarded via exMemId;
  - on a load producer, 2 stall cycles.
REQ-028 stallCycles SHALL increment on every rising edge with stall=1 and hold at 16'hFFFF.
REQ-029 All outputs other than stallCycles SHALL be combinational from the inputs and shadow state, with no added latency.

Reset
REQ-030 While reset=1, EXs and MEMs SHALL be all-zero and stallCycles SHALL be 0.
REQ-031 With cleared shadows, stall, bubble and all forward selects SHALL be 0, and ifIdWrIn SHALL be 1.
REQ-032 Reset asserted mid-stall SHALL drop stall to 0 without waiting for clk; the first edge after reset deasserts loads EXs normally.

Verification
REQ-033 ALU-to-ALU: add r3 writes, next op reads rS1=3 -> exMemExA=1, stall=0; one op later memWbExA=1.
REQ-034 Load-use: lw r5, then an op with rS2=5 -> stall=1 for exactly 1 cycle, stallCycles=1; next cycle memWbExB=1, stall=0.
REQ-035 Branch after ALU: add r4, then beqz r4 -> 1 stall cycle, then exMemIdA=1; branch after lw r4 -> 2 stall cycles, stallCycles=2.
REQ-036 r0 and unused sources: producer writes r0, consumer rS1=0; or useS1=0 with a matching rS1 -> all selects 0, stall=0.
REQ-037 Priority: two back-to-back writers of r7, then a reader of r7 -> exMemExA=1, memWbExA=0.
REQ-038 Saturation and reset: force stallCycles to FFFF plus 3 more stalls -> stays FFFF; pulse reset between edges -> stallCycles=0, stall=0 immediately.
